// File: rtl/amba_axi4_stream_seda_pkg.sv
// Shared types and constants for the AXI4-Stream packet sink: FSM encoding,
// stat_err bit positions and the port/beat-level typedefs.
package amba_axi4_stream_seda_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } axi4s_state_e;

    localparam int ERR_TID       = 0;
    localparam int ERR_DEST      = 1;
    localparam int ERR_NULL_STRB = 2;
    localparam int ERR_LEN_SAT   = 3;

    // A beat carries at most 8 bytes: count fits in 4 bits, sum in 11 bits.
    localparam int BEAT_CNT_W = 4;
    localparam int BEAT_SUM_W = 11;

    typedef logic [3:0]            axi4s_err_t;
    typedef logic [15:0]           axi4s_csum_t;
    typedef logic [BEAT_CNT_W-1:0] axi4s_beat_cnt_t;
    typedef logic [BEAT_SUM_W-1:0] axi4s_beat_sum_t;

endpackage

// File: rtl/amba_axi4_stream_pkt_sink_if.sv
// AXI4-Stream bundle; the packet sink attaches through the slave modport.
interface amba_axi4_stream_pkt_sink_if #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ID_WIDTH         = 8,
    parameter int DEST_WIDTH       = 8,
    parameter int USER_WIDTH       = 1
);
    logic                          TVALID;
    logic                          TREADY;
    logic [8*DATA_WIDTH_BYTES-1:0] TDATA;
    logic [DATA_WIDTH_BYTES-1:0]   TSTRB;
    logic [DATA_WIDTH_BYTES-1:0]   TKEEP;
    logic                          TLAST;
    logic [ID_WIDTH-1:0]           TID;
    logic [DEST_WIDTH-1:0]         TDEST;
    logic [USER_WIDTH-1:0]         TUSER;

    modport master (
        output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/amba_axi4_stream_byte_acc.sv
// Per-beat byte statistics: count of kept bytes, sum of kept data bytes,
// and a flag for any null byte that still has its strobe set.
module amba_axi4_stream_byte_acc
    import amba_axi4_stream_seda_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 1
) (
    input  logic [8*DATA_WIDTH_BYTES-1:0] data,
    input  logic [DATA_WIDTH_BYTES-1:0]   keep,
    input  logic [DATA_WIDTH_BYTES-1:0]   strb,
    output axi4s_beat_cnt_t               cnt,
    output axi4s_beat_sum_t               sum,
    output logic                          null_strb
);

    // NOTE: blocking assignments here build a running sum inside one
    // combinational evaluation; defaults first keep the block latch-free.
    always_comb begin
        cnt       = '0;
        sum       = '0;
        null_strb = 1'b0;
        for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            if (keep[i]) begin
                cnt = cnt + axi4s_beat_cnt_t'(1);
                if (strb[i]) begin
                    sum = sum + axi4s_beat_sum_t'(data[8*i +: 8]);
                end
            end else if (strb[i]) begin
                null_strb = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amba_axi4_stream_pkt_sink.sv
// AXI4-Stream packet sink: accumulates byte count, checksum and error flags
// per packet and reports them through a valid/ready status channel.
module amba_axi4_stream_pkt_sink
    import amba_axi4_stream_seda_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ID_WIDTH         = 8,
    parameter int DEST_WIDTH       = 8,
    parameter int USER_WIDTH       = 1,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    amba_axi4_stream_pkt_sink_if.slave axis,
    output logic                      stat_valid,
    input  logic                      stat_ready,
    output logic [LEN_WIDTH-1:0]      stat_len,
    output axi4s_csum_t               stat_csum,
    output logic [ID_WIDTH-1:0]       stat_id,
    output logic [DEST_WIDTH-1:0]     stat_dest,
    output axi4s_err_t                stat_err
);

    localparam int                   SUM_W   = LEN_WIDTH + BEAT_CNT_W;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    axi4s_state_e          state_q, state_d;
    logic                  tready_q;
    logic                  stat_valid_d;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  acc_len, nxt_len;
    axi4s_csum_t           acc_csum, nxt_csum;
    axi4s_err_t            acc_err, nxt_err;
    logic [ID_WIDTH-1:0]   ref_id, nxt_id;
    logic [DEST_WIDTH-1:0] ref_dest, nxt_dest;
    logic [SUM_W-1:0]      len_sum;
    axi4s_beat_cnt_t       beat_cnt;
    axi4s_beat_sum_t       beat_sum;
    logic                  beat_null_strb;
    logic [USER_WIDTH-1:0] unused_user;

    assign unused_user = axis.TUSER;
    assign axis.TREADY = tready_q;
    assign accept      = axis.TVALID & tready_q;

    amba_axi4_stream_byte_acc #(
        .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES)
    ) u_byte_acc (
        .data      (axis.TDATA),
        .keep      (axis.TKEEP),
        .strb      (axis.TSTRB),
        .cnt       (beat_cnt),
        .sum       (beat_sum),
        .null_strb (beat_null_strb)
    );

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = axis.TLAST ? ST_IDLE : ST_RECV;
        end
    end

    always_comb begin
        stat_valid_d = stat_valid;
        if (accept && axis.TLAST) begin
            stat_valid_d = 1'b1;
        end else if (stat_valid && stat_ready) begin
            stat_valid_d = 1'b0;
        end
    end

    // Accumulators are zero whenever no packet is open, so the first beat
    // adds onto a clean base without a separate IDLE path.
    always_comb begin
        len_sum  = SUM_W'(acc_len) + SUM_W'(beat_cnt);
        nxt_len  = len_sum[LEN_WIDTH-1:0];
        nxt_csum = acc_csum + axi4s_csum_t'(beat_sum);
        nxt_err  = acc_err;
        nxt_id   = ref_id;
        nxt_dest = ref_dest;
        if (len_sum > SUM_W'(LEN_MAX)) begin
            nxt_len              = LEN_MAX;
            nxt_err[ERR_LEN_SAT] = 1'b1;
        end
        if (beat_null_strb) begin
            nxt_err[ERR_NULL_STRB] = 1'b1;
        end
        if (state_q == ST_IDLE) begin
            nxt_id   = axis.TID;
            nxt_dest = axis.TDEST;
        end else begin
            if (axis.TID != ref_id)     nxt_err[ERR_TID]  = 1'b1;
            if (axis.TDEST != ref_dest) nxt_err[ERR_DEST] = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            tready_q   <= 1'b0;
            stat_valid <= 1'b0;
            stat_len   <= '0;
            stat_csum  <= '0;
            stat_id    <= '0;
            stat_dest  <= '0;
            stat_err   <= '0;
            acc_len    <= '0;
            acc_csum   <= '0;
            acc_err    <= '0;
            ref_id     <= '0;
            ref_dest   <= '0;
        end else begin
            stat_valid <= stat_valid_d;
            tready_q   <= ~stat_valid_d;
            if (accept) begin
                if (axis.TLAST) begin
                    stat_len  <= nxt_len;
                    stat_csum <= nxt_csum;
                    stat_id   <= nxt_id;
                    stat_dest <= nxt_dest;
                    stat_err  <= nxt_err;
                    acc_len   <= '0;
                    acc_csum  <= '0;
                    acc_err   <= '0;
                    ref_id    <= '0;
                    ref_dest  <= '0;
                end else begin
                    acc_len   <= nxt_len;
                    acc_csum  <= nxt_csum;
                    acc_err   <= nxt_err;
                    ref_id    <= nxt_id;
                    ref_dest  <= nxt_dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_amba_axi4_stream_pkt_sink.sv
// Randomized scoreboard bench for the packet sink: a 4-byte/16-bit-length
// instance and a 1-byte/4-bit-length instance checked against a packet model.
module tb_amba_axi4_stream_pkt_sink;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
    } beat_t;

    typedef struct {
        int          len;
        logic [15:0] csum;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [3:0]  err;
    } stat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   rst_q = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst_n;

    amba_axi4_stream_pkt_sink_if #(.DATA_WIDTH_BYTES(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) a_if ();
    amba_axi4_stream_pkt_sink_if #(.DATA_WIDTH_BYTES(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) b_if ();

    logic        stat_valid_a, stat_ready_a;
    logic [15:0] stat_len_a;
    logic [15:0] stat_csum_a;
    logic [7:0]  stat_id_a, stat_dest_a;
    logic [3:0]  stat_err_a;
    logic        stat_valid_b, stat_ready_b;
    logic [3:0]  stat_len_b;
    logic [15:0] stat_csum_b;
    logic [7:0]  stat_id_b, stat_dest_b;
    logic [3:0]  stat_err_b;

    amba_axi4_stream_pkt_sink #(
        .DATA_WIDTH_BYTES(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(16)
    ) dut_a (
        .ACLK(clk), .ARESETn(rst_n), .axis(a_if),
        .stat_valid(stat_valid_a), .stat_ready(stat_ready_a), .stat_len(stat_len_a),
        .stat_csum(stat_csum_a), .stat_id(stat_id_a), .stat_dest(stat_dest_a), .stat_err(stat_err_a)
    );

    amba_axi4_stream_pkt_sink #(
        .DATA_WIDTH_BYTES(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(4)
    ) dut_b (
        .ACLK(clk), .ARESETn(rst_n), .axis(b_if),
        .stat_valid(stat_valid_b), .stat_ready(stat_ready_b), .stat_len(stat_len_b),
        .stat_csum(stat_csum_b), .stat_id(stat_id_b), .stat_dest(stat_dest_b), .stat_err(stat_err_b)
    );

    stat_t exp_a[$];
    stat_t exp_b[$];
    beat_t pkt_q[$];
    int    hold_a = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_stat(input string tag, input logic [15:0] len, input logic [15:0] csum,
                              input logic [7:0] id, input logic [7:0] dest, input logic [3:0] err,
                              input stat_t e);
        check({tag, "_len"},  32'(len),  32'(e.len));
        check({tag, "_csum"}, 32'(csum), 32'(e.csum));
        check({tag, "_id"},   32'(id),   32'(e.id));
        check({tag, "_dest"}, 32'(dest), 32'(e.dest));
        check({tag, "_err"},  32'(err),  32'(e.err));
    endtask

    // Packet-level reference: totals over the whole beat list.
    function automatic stat_t model(input beat_t pkt[$], input int nbytes, input int len_max);
        stat_t s;
        int    total = 0;
        s.csum = '0;
        s.err  = '0;
        s.id   = pkt[0].id;
        s.dest = pkt[0].dest;
        foreach (pkt[k]) begin
            if (k > 0 && pkt[k].id != s.id)     s.err[0] = 1'b1;
            if (k > 0 && pkt[k].dest != s.dest) s.err[1] = 1'b1;
            for (int i = 0; i < nbytes; i++) begin
                if (pkt[k].keep[i]) begin
                    total++;
                    if (pkt[k].strb[i]) s.csum = s.csum + 16'(pkt[k].data[8*i +: 8]);
                end else if (pkt[k].strb[i]) begin
                    s.err[2] = 1'b1;
                end
            end
        end
        if (total > len_max) begin
            s.len    = len_max;
            s.err[3] = 1'b1;
        end else begin
            s.len = total;
        end
        return s;
    endfunction

    task automatic build_pkt(input int nbeats, input int nbytes);
        logic [3:0] mask = 4'((1 << nbytes) - 1);
        logic [7:0] id0  = 8'($urandom);
        logic [7:0] d0   = 8'($urandom);
        pkt_q.delete();
        for (int k = 0; k < nbeats; k++) begin
            beat_t b;
            b.data = $urandom;
            b.keep = 4'($urandom_range(0, 15)) & mask;
            b.strb = ($urandom_range(0, 3) == 0) ? (4'($urandom) & mask) : b.keep;
            b.id   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : id0;
            b.dest = ($urandom_range(0, 7) == 0) ? 8'($urandom) : d0;
            b.last = (k == nbeats - 1);
            pkt_q.push_back(b);
        end
    endtask

    // Drivers: entered and left on a falling edge.
    task automatic drive_beat_a(input beat_t b);
        int t = 0;
        a_if.TVALID = 1'b1;
        a_if.TDATA  = b.data;
        a_if.TKEEP  = b.keep;
        a_if.TSTRB  = b.strb;
        a_if.TLAST  = b.last;
        a_if.TID    = b.id;
        a_if.TDEST  = b.dest;
        a_if.TUSER  = 1'($urandom);
        while (!a_if.TREADY && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL a_beat_timeout: TREADY stuck at 0, required 1 within 500 cycles");
        end
        @(negedge clk);
        a_if.TVALID = 1'b0;
    endtask

    task automatic drive_beat_b(input beat_t b);
        int t = 0;
        b_if.TVALID = 1'b1;
        b_if.TDATA  = b.data[7:0];
        b_if.TKEEP  = b.keep[0:0];
        b_if.TSTRB  = b.strb[0:0];
        b_if.TLAST  = b.last;
        b_if.TID    = b.id;
        b_if.TDEST  = b.dest;
        b_if.TUSER  = 1'($urandom);
        while (!b_if.TREADY && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL b_beat_timeout: TREADY stuck at 0, required 1 within 500 cycles");
        end
        @(negedge clk);
        b_if.TVALID = 1'b0;
    endtask

    task automatic send_pkt_a();
        exp_a.push_back(model(pkt_q, 4, 65535));
        foreach (pkt_q[k]) begin
            drive_beat_a(pkt_q[k]);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic send_pkt_b();
        exp_b.push_back(model(pkt_q, 1, 15));
        foreach (pkt_q[k]) begin
            drive_beat_b(pkt_q[k]);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input bit sel_b);
        int t = 0;
        while (((sel_b ? exp_b.size() : exp_a.size()) != 0 || (sel_b ? stat_valid_b : stat_valid_a))
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: status still pending, required drained within 3000 cycles",
                     sel_b ? "b" : "a");
        end
    endtask

    // Monitor A: pops one expectation per status and rechecks it every held cycle.
    bit    seen_a = 0, have_a = 0, hs_a = 0, rel_a = 0;
    stat_t cur_a;
    always @(negedge clk) begin
        if (!rst_q) begin
            seen_a = 0; hs_a = 0; rel_a = 0; stat_ready_a = 1'b0;
        end else begin
            if (hs_a) begin
                check("a_post_handshake_valid",  32'(stat_valid_a), 32'd0);
                check("a_post_handshake_tready", 32'(a_if.TREADY), 32'd1);
                hs_a = 0;
            end
            if (stat_valid_a) begin
                if (!seen_a) begin
                    seen_a = 1;
                    have_a = exp_a.size() != 0;
                    if (have_a) cur_a = exp_a.pop_front();
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_status: got len %0d, required no status", stat_len_a);
                    end
                end
                if (have_a) check_stat("a", stat_len_a, stat_csum_a, stat_id_a, stat_dest_a, stat_err_a, cur_a);
                check("a_tready_while_status", 32'(a_if.TREADY), 32'd0);
                if (hold_a > 0) begin
                    stat_ready_a = 1'b0;
                    hold_a--;
                    rel_a = (hold_a == 0);
                end else if (rel_a) begin
                    stat_ready_a = 1'b1;
                    rel_a = 0;
                end else begin
                    stat_ready_a = 1'($urandom_range(0, 1));
                end
                hs_a = stat_ready_a;
            end else begin
                seen_a = 0;
                stat_ready_a = 1'($urandom_range(0, 1));
            end
        end
    end

    bit    seen_b = 0, have_b = 0, hs_b = 0;
    stat_t cur_b;
    always @(negedge clk) begin
        if (!rst_q) begin
            seen_b = 0; hs_b = 0; stat_ready_b = 1'b0;
        end else begin
            if (hs_b) begin
                check("b_post_handshake_valid",  32'(stat_valid_b), 32'd0);
                check("b_post_handshake_tready", 32'(b_if.TREADY), 32'd1);
                hs_b = 0;
            end
            if (stat_valid_b) begin
                if (!seen_b) begin
                    seen_b = 1;
                    have_b = exp_b.size() != 0;
                    if (have_b) cur_b = exp_b.pop_front();
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_status: got len %0d, required no status", stat_len_b);
                    end
                end
                if (have_b) check_stat("b", 16'(stat_len_b), stat_csum_b, stat_id_b, stat_dest_b, stat_err_b, cur_b);
                stat_ready_b = 1'($urandom_range(0, 1));
                hs_b = stat_ready_b;
            end else begin
                seen_b = 0;
                stat_ready_b = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.TVALID = 1'b0; a_if.TDATA = '0; a_if.TKEEP = '0; a_if.TSTRB = '0;
        a_if.TLAST = 1'b0; a_if.TID = '0; a_if.TDEST = '0; a_if.TUSER = '0;
        b_if.TVALID = 1'b0; b_if.TDATA = '0; b_if.TKEEP = '0; b_if.TSTRB = '0;
        b_if.TLAST = 1'b0; b_if.TID = '0; b_if.TDEST = '0; b_if.TUSER = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tready_a", 32'(a_if.TREADY), 32'd0);
        check("rst_valid_a",  32'(stat_valid_a), 32'd0);
        check("rst_len_a",    32'(stat_len_a), 32'd0);
        check("rst_csum_a",   32'(stat_csum_a), 32'd0);
        check("rst_id_a",     32'(stat_id_a), 32'd0);
        check("rst_dest_a",   32'(stat_dest_a), 32'd0);
        check("rst_err_a",    32'(stat_err_a), 32'd0);
        check("rst_tready_b", 32'(b_if.TREADY), 32'd0);
        check("rst_valid_b",  32'(stat_valid_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tready_a", 32'(a_if.TREADY), 32'd1);
        check("post_rst_tready_b", 32'(b_if.TREADY), 32'd1);

        // Two-beat packet: bytes 1..6, length 6, checksum 0x15.
        pkt_q.delete();
        pkt_q.push_back('{data: 32'h04030201, keep: 4'hF, strb: 4'hF, last: 1'b0, id: 8'h00, dest: 8'h00});
        pkt_q.push_back('{data: 32'h00000605, keep: 4'h3, strb: 4'h3, last: 1'b1, id: 8'h00, dest: 8'h00});
        send_pkt_a();

        // TID changes on the second beat.
        pkt_q.delete();
        pkt_q.push_back('{data: 32'h11223344, keep: 4'hF, strb: 4'hF, last: 1'b0, id: 8'h05, dest: 8'h09});
        pkt_q.push_back('{data: 32'h55667788, keep: 4'hF, strb: 4'hF, last: 1'b1, id: 8'h06, dest: 8'h09});
        send_pkt_a();

        // Status back-pressure for 10 cycles.
        wait_idle(1'b0);
        hold_a = 10;
        build_pkt(3, 4);
        send_pkt_a();
        wait_idle(1'b0);

        // Null bytes with strobe set, single beat.
        pkt_q.delete();
        pkt_q.push_back('{data: 32'hDEADBEEF, keep: 4'h0, strb: 4'h1, last: 1'b1, id: 8'h3C, dest: 8'hA5});
        send_pkt_a();

        // All-null beat in the middle of a packet, then a single-beat packet.
        pkt_q.delete();
        pkt_q.push_back('{data: 32'h000000FF, keep: 4'h1, strb: 4'h1, last: 1'b0, id: 8'h01, dest: 8'h02});
        pkt_q.push_back('{data: 32'hFFFFFFFF, keep: 4'h0, strb: 4'h0, last: 1'b0, id: 8'h01, dest: 8'h02});
        pkt_q.push_back('{data: 32'h0000FF00, keep: 4'h2, strb: 4'h2, last: 1'b1, id: 8'h01, dest: 8'h07});
        send_pkt_a();
        build_pkt(1, 4);
        send_pkt_a();

        // Saturating length on the narrow instance, then a clean follow-up.
        pkt_q.delete();
        for (int k = 0; k < 20; k++)
            pkt_q.push_back('{data: 32'($urandom_range(0, 255)), keep: 4'h1, strb: 4'h1,
                              last: (k == 19), id: 8'h42, dest: 8'h24});
        send_pkt_b();
        build_pkt(3, 1);
        send_pkt_b();
        for (int n = 0; n < 15; n++) begin
            build_pkt($urandom_range(1, 24), 1);
            send_pkt_b();
        end
        wait_idle(1'b1);

        // Reset while a status is held pending: it must vanish.
        wait_idle(1'b0);
        hold_a = 1000;
        build_pkt(2, 4);
        send_pkt_a();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        hold_a = 0;
        check("rst_pending_valid_a", 32'(stat_valid_a), 32'd0);
        check("rst_pending_len_a",   32'(stat_len_a), 32'd0);
        check("rst_pending_tready_a", 32'(a_if.TREADY), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an open packet.
        build_pkt(4, 4);
        for (int k = 0; k < 3; k++) drive_beat_a(pkt_q[k]);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_a",  32'(stat_valid_a), 32'd0);
        check("rst_mid_tready_a", 32'(a_if.TREADY), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_tready_up_a", 32'(a_if.TREADY), 32'd1);
        build_pkt(2, 4);
        send_pkt_a();

        for (int n = 0; n < 40; n++) begin
            build_pkt($urandom_range(1, 6), 4);
            send_pkt_a();
        end
        wait_idle(1'b0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
